param_fifo: RTL and testbench

//  Synchronous FIFO, parametrised in data width and depth. Successor to the fixed 8-bit queue.

---
 rtl/fifo_defs_pkg.sv | 25 ++
 rtl/param_fifo_ram.sv | 29 ++
 rtl/param_fifo.sv | 108 ++++++++++
 tb/tb_param_fifo.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_defs_pkg.sv
// Shared definitions for the parametrised FIFO:
// count-width macro, parameter legality helper, reset constants.
`ifndef FIFO_DEFS_PKG_SV
`define FIFO_DEFS_PKG_SV

`define FIFO_CW(d) ($clog2((d) + 1))

package fifo_defs;

  localparam logic RST_FLAG  = 1'b0;
  localparam logic RST_VALID = 1'b0;

  function automatic bit params_ok(
    input int depth,
    input int af,
    input int ae
  );
    return (depth >= 2) && (af >= 0) &&
           (af <= depth) && (ae >= 0) &&
           (ae < depth);
  endfunction

endpackage

`endif

// File: rtl/param_fifo_ram.sv
// WIDTH x DEPTH storage: one synchronous write port,
// one registered read port, no reset.
module param_fifo_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_re,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we)
      r_mem[i_waddr] <= i_wdata;
    if (i_re)
      r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/param_fifo.sv
// Synchronous FIFO: pointers, occupancy, threshold flags,
// registered read with valid strobe, sticky error flags.
module param_fifo #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = 6,
  parameter int AE_LEVEL = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [WIDTH-1:0]             dataIn,
  input  logic                         enqueue,
  input  logic                         dequeue,
  input  logic                         clearErr,
  output logic [WIDTH-1:0]             dataOut,
  output logic                         dataValid,
  output logic                         full,
  output logic                         empty,
  output logic                         almostFull,
  output logic                         almostEmpty,
  output logic [`FIFO_CW(DEPTH)-1:0]   count,
  output logic                         overflow,
  output logic                         underflow
);

  import fifo_defs::*;

  localparam int CW = `FIFO_CW(DEPTH);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if (!params_ok(DEPTH, AF_LEVEL, AE_LEVEL)) begin : g_bad_params
    $error("param_fifo: illegal DEPTH/AF_LEVEL/AE_LEVEL");
  end

  logic [AW-1:0]    r_wrPtr;
  logic [AW-1:0]    r_rdPtr;
  logic [CW-1:0]    r_count;
  logic             r_valid;
  logic             r_ovf;
  logic             r_unf;
  logic             r_rdSeen;
  logic             w_full;
  logic             w_empty;
  logic             w_wrOk;
  logic             w_rdOk;
  logic [WIDTH-1:0] w_rdData;

  function automatic logic [AW-1:0] nxt(
    input logic [AW-1:0] p
  );
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_wrOk  = enqueue & (~w_full | dequeue);
  assign w_rdOk  = dequeue & ~w_empty;

  param_fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_wrOk & ~rst),
    .i_waddr (r_wrPtr),
    .i_wdata (dataIn),
    .i_re    (w_rdOk & ~rst),
    .i_raddr (r_rdPtr),
    .o_rdata (w_rdData)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrPtr  <= '0;
      r_rdPtr  <= '0;
      r_count  <= '0;
      r_valid  <= RST_VALID;
      r_ovf    <= RST_FLAG;
      r_unf    <= RST_FLAG;
      r_rdSeen <= RST_FLAG;
    end else begin
      if (w_wrOk)
        r_wrPtr <= nxt(r_wrPtr);
      if (w_rdOk) begin
        r_rdPtr  <= nxt(r_rdPtr);
        r_rdSeen <= 1'b1;
      end
      r_count <= r_count + CW'(w_wrOk) - CW'(w_rdOk);
      r_valid <= w_rdOk;
      // a fresh error in the clearing cycle keeps the flag set
      r_ovf <= (r_ovf & ~clearErr) | (enqueue & ~w_wrOk);
      r_unf <= (r_unf & ~clearErr) | (dequeue & ~w_rdOk);
    end
  end

  // RAM read register has no reset; mask it until the first read
  assign dataOut     = r_rdSeen ? w_rdData : '0;
  assign dataValid   = r_valid;
  assign full        = w_full;
  assign empty       = w_empty;
  assign almostFull  = (r_count >= CW'(AF_LEVEL));
  assign almostEmpty = (r_count <= CW'(AE_LEVEL));
  assign count       = r_count;
  assign overflow    = r_ovf;
  assign underflow   = r_unf;

endmodule

// File: tb/tb_param_fifo.sv
// Self-checking bench for param_fifo: directed scenarios
// plus random traffic against a queue-based reference model.
module tb_param_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int AE    = 2;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [WIDTH-1:0] dataIn = '0;
  logic             enqueue = 1'b0;
  logic             dequeue = 1'b0;
  logic             clearErr = 1'b0;
  logic [WIDTH-1:0] dataOut;
  logic             dataValid;
  logic             full;
  logic             empty;
  logic             almostFull;
  logic             almostEmpty;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;

  int n_checks = 0;
  int n_errors = 0;

  logic [WIDTH-1:0] q[$];
  logic [WIDTH-1:0] m_do = '0;
  bit               m_dv = 0;
  bit               m_ovf = 0;
  bit               m_unf = 0;

  always #5 clk = ~clk;

  param_fifo #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .AF_LEVEL (AF),
    .AE_LEVEL (AE)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .dataIn      (dataIn),
    .enqueue     (enqueue),
    .dequeue     (dequeue),
    .clearErr    (clearErr),
    .dataOut     (dataOut),
    .dataValid   (dataValid),
    .full        (full),
    .empty       (empty),
    .almostFull  (almostFull),
    .almostEmpty (almostEmpty),
    .count       (count),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)",
               tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    chk("count", 32'(count), 32'(n));
    chk("full", 32'(full), 32'(n == DEPTH));
    chk("empty", 32'(empty), 32'(n == 0));
    chk("almostFull", 32'(almostFull), 32'(n >= AF));
    chk("almostEmpty", 32'(almostEmpty), 32'(n <= AE));
    chk("dataValid", 32'(dataValid), 32'(m_dv));
    chk("dataOut", 32'(dataOut), 32'(m_do));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("underflow", 32'(underflow), 32'(m_unf));
  endtask

  // drive one cycle, advance the model on the same edge, compare
  task automatic step(
    input bit         r,
    input bit         e,
    input bit         d,
    input bit         c,
    input logic [7:0] din
  );
    bit wr;
    bit rd;
    rst      = r;
    enqueue  = e;
    dequeue  = d;
    clearErr = c;
    dataIn   = din;
    @(posedge clk);
    #1;
    if (r) begin
      q.delete();
      m_do  = '0;
      m_dv  = 0;
      m_ovf = 0;
      m_unf = 0;
    end else begin
      wr = e && (q.size() < DEPTH || d);
      rd = d && (q.size() > 0);
      if (rd) begin
        m_do = q.pop_front();
        m_dv = 1;
      end else begin
        m_dv = 0;
      end
      if (wr)
        q.push_back(din);
      m_ovf = (m_ovf && !c) || (e && !wr);
      m_unf = (m_unf && !c) || (d && !rd);
    end
    check_all();
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 8'h00);
  endtask

  initial begin
    logic [7:0] exp3 [3];
    exp3[0] = 8'hF0;
    exp3[1] = 8'h0F;
    exp3[2] = 8'h01;

    // reset state
    step(1, 0, 0, 0, 8'h00);
    step(1, 0, 0, 0, 8'h00);
    idle();
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_dataOut", 32'(dataOut), 32'd0);

    // basic ordering
    step(0, 1, 0, 0, 8'hF0);
    step(0, 1, 0, 0, 8'h0F);
    step(0, 1, 0, 0, 8'h01);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 0, 8'h00);
      chk("order_data", 32'(dataOut), 32'(exp3[i]));
      chk("order_valid", 32'(dataValid), 32'd1);
    end
    idle();
    chk("order_empty", 32'(empty), 32'd1);

    // overfill
    for (int i = 0; i < 10; i++)
      step(0, 1, 0, 0, 8'(i));
    chk("ovf_full", 32'(full), 32'd1);
    chk("ovf_count", 32'(count), 32'd8);
    chk("ovf_flag", 32'(overflow), 32'd1);
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 1, 0, 8'h00);
      chk("ovf_drain", 32'(dataOut), 32'(i));
    end
    chk("ovf_empty", 32'(empty), 32'd1);
    step(0, 0, 0, 1, 8'h00);
    chk("ovf_clear", 32'(overflow), 32'd0);

    // full with simultaneous enqueue/dequeue, three wraps
    for (int i = 0; i < 8; i++)
      step(0, 1, 0, 0, 8'(8'h10 + i));
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 8; k++) begin
        step(0, 1, 1, 0, 8'(8'h40 + 8 * r + k));
        chk("wrap_data", 32'(dataOut),
            32'(r == 0 ? 8'h10 + k : 8'h40 + 8 * (r - 1) + k));
        chk("wrap_count", 32'(count), 32'd8);
      end
    end
    step(0, 1, 1, 0, 8'hAA);
    chk("wrap_noovf", 32'(overflow), 32'd0);
    for (int i = 0; i < 8; i++)
      step(0, 0, 1, 0, 8'h00);
    chk("wrap_last", 32'(dataOut), 32'hAA);

    // underflow paths
    step(0, 0, 1, 0, 8'h00);
    chk("unf_flag", 32'(underflow), 32'd1);
    chk("unf_valid", 32'(dataValid), 32'd0);
    step(0, 1, 1, 0, 8'h55);
    chk("unf_count", 32'(count), 32'd1);
    step(0, 0, 0, 1, 8'h00);
    chk("unf_clear", 32'(underflow), 32'd0);
    step(0, 0, 1, 1, 8'h00);
    chk("unf_kept", 32'(dataOut), 32'h55);
    step(0, 0, 1, 1, 8'h00);
    chk("unf_win", 32'(underflow), 32'd1);
    step(0, 0, 0, 1, 8'h00);

    // thresholds and mid-fill reset
    for (int i = 0; i < 9; i++)
      step(0, 1, 0, 0, 8'(i));
    step(1, 0, 0, 0, 8'h00);
    for (int i = 0; i < 5; i++)
      step(0, 1, 0, 0, 8'(i));
    chk("mid_count5", 32'(count), 32'd5);
    step(1, 1, 0, 0, 8'h77);
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_empty", 32'(empty), 32'd1);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 199) == 0,
           $urandom_range(0, 99) < 55,
           $urandom_range(0, 99) < 50,
           $urandom_range(0, 99) < 5,
           8'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
